// File: rtl/float_adder_pipe_norm.sv
// Normalize/round back end of a single-precision adder: two-register pipeline.
// Register A holds the raw sum plus its leading-zero count. Register B holds
// the normalized, rounded result. The macro FADD_NORM_FLAGS_EN adds a
// registered flags output {overflow, underflow, inexact}.
module float_adder_pipe_norm (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  n_rm,
  input  logic        n_sign,
  input  logic [7:0]  n_exp,
  input  logic [27:0] n_frac,
  input  logic        n_inf_nan,
  input  logic [22:0] n_inf_nan_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] s
`ifdef FADD_NORM_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  logic        a_valid_q, out_valid_q;
  logic [1:0]  a_rm_q;
  logic        a_sign_q, a_inf_q;
  logic [7:0]  a_exp_q;
  logic [27:0] a_frac_q;
  logic [4:0]  a_lz_q, lz_d;
  logic [22:0] a_infrac_q;
  logic [31:0] s_q, s_d;
  logic        a_adv, b_adv;

  logic [26:0] m_n;
  logic [9:0]  e_n, e_r;
  logic [7:0]  sh;
  logic        g, r, st, lsb, grs_any, inc, away, ovf;
  logic [24:0] sum;
  logic [23:0] mant;

  assign b_adv     = !out_valid_q || out_ready;
  assign a_adv     = !a_valid_q || b_adv;
  assign in_ready  = rst || a_adv;
  assign out_valid = out_valid_q;
  assign s         = s_q;

  // Leading zeros of n_frac[26:0]; the highest set bit wins (27 when all zero).
  always_comb begin
    lz_d = 5'd27;
    for (int unsigned i = 0; i < 27; i++)
      if (n_frac[i]) lz_d = 5'(26 - i);
  end

  // Register A valid flag.
  always_ff @(posedge clk) begin
    if (rst)        a_valid_q <= 1'b0;
    else if (a_adv) a_valid_q <= in_valid;
  end

  // Register A payload; no reset needed.
  always_ff @(posedge clk) begin
    if (!rst && a_adv && in_valid) begin
      a_rm_q     <= n_rm;
      a_sign_q   <= n_sign;
      a_exp_q    <= n_exp;
      a_frac_q   <= n_frac;
      a_lz_q     <= lz_d;
      a_inf_q    <= n_inf_nan;
      a_infrac_q <= n_inf_nan_frac;
    end
  end

  // Normalize: carry shifts right with sticky, otherwise shift left by lz or into denormal range.
  always_comb begin
    m_n = '0;
    e_n = '0;
    sh  = '0;
    if (a_frac_q[27]) begin
      m_n = {a_frac_q[27:2], a_frac_q[1] | a_frac_q[0]};
      e_n = {2'b00, a_exp_q} + 10'd1;
    end else if (a_exp_q > {3'b000, a_lz_q}) begin
      m_n = a_frac_q[26:0] << a_lz_q;
      e_n = {2'b00, a_exp_q} - {5'd0, a_lz_q};
    end else begin
      sh  = (a_exp_q == 8'd0) ? 8'd0 : a_exp_q - 8'd1;
      m_n = a_frac_q[26:0] << sh;
      e_n = '0;
    end
  end

  // Round, renormalize, detect overflow and select the packed result.
  always_comb begin
    g       = m_n[2];
    r       = m_n[1];
    st      = m_n[0];
    lsb     = m_n[3];
    grs_any = g | r | st;
    case (a_rm_q)
      2'b00:   inc = g & (r | st | lsb);
      2'b01:   inc = a_sign_q & grs_any;
      2'b10:   inc = !a_sign_q & grs_any;
      default: inc = 1'b0;
    endcase
    away = (a_rm_q == 2'b01 && a_sign_q) || (a_rm_q == 2'b10 && !a_sign_q);
    sum  = {1'b0, m_n[26:3]} + {24'd0, inc};
    if (sum[24]) begin
      mant = sum[24:1];
      e_r  = e_n + 10'd1;
    end else begin
      mant = sum[23:0];
      e_r  = e_n;
    end
    // A denormal that rounds up into the hidden-bit position becomes the smallest normal.
    if (e_r == 10'd0 && mant[23]) e_r = 10'd1;
    ovf = e_r >= 10'd255;
    if (a_inf_q)
      s_d = {a_sign_q, 8'hFF, a_infrac_q};
    else if (a_frac_q == 28'd0)
      s_d = {a_rm_q == 2'b01, 31'd0};
    else if (ovf)
      s_d = (a_rm_q == 2'b00 || away) ? {a_sign_q, 8'hFF, 23'd0}
                                      : {a_sign_q, 8'hFE, 23'h7FFFFF};
    else
      s_d = {a_sign_q, e_r[7:0], mant[22:0]};
  end

  // Register B: output valid and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
    end else if (b_adv) begin
      out_valid_q <= a_valid_q;
      if (a_valid_q) s_q <= s_d;
    end
  end

`ifdef FADD_NORM_FLAGS_EN
  logic [2:0] flags_q, flags_d;
  logic       arith;

  // Exception flags for arithmetic results; specials and exact zero raise none.
  always_comb begin
    arith   = !a_inf_q && (a_frac_q != 28'd0);
    flags_d = '0;
    if (arith) begin
      if (ovf) flags_d = 3'b101;
      else     flags_d = {1'b0, (e_r == 10'd0) && grs_any, grs_any};
    end
  end

  // Flags register, captured alongside s.
  always_ff @(posedge clk) begin
    if (rst)                     flags_q <= '0;
    else if (b_adv && a_valid_q) flags_q <= flags_d;
  end

  assign flags = flags_q;
`endif

endmodule

// File: tb/tb_float_adder_pipe_norm.sv
// Bench for float_adder_pipe_norm: directed vectors, backpressure and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_float_adder_pipe_norm;

  typedef struct {
    logic [1:0]  rm;
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] frac;
    logic        inf;
    logic [22:0] infrac;
  } item_t;

  typedef struct {
    item_t       it;
    logic [31:0] s_exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, n_sign, n_inf_nan, out_valid, out_ready;
  logic [1:0]  n_rm;
  logic [7:0]  n_exp;
  logic [27:0] n_frac;
  logic [22:0] n_inf_nan_frac;
  logic [31:0] s;
`ifdef FADD_NORM_FLAGS_EN
  logic [2:0]  flags;
`endif

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  logic [34:0] expq[$];
  vec_t        vq[$];

  float_adder_pipe_norm dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .n_rm(n_rm), .n_sign(n_sign), .n_exp(n_exp), .n_frac(n_frac),
    .n_inf_nan(n_inf_nan), .n_inf_nan_frac(n_inf_nan_frac),
    .out_valid(out_valid), .out_ready(out_ready), .s(s)
`ifdef FADD_NORM_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic item_t mk(input logic [1:0] rm, input logic sign, input logic [7:0] e,
                               input logic [27:0] f, input logic inf, input logic [22:0] inff);
    item_t it;
    it.rm = rm; it.sign = sign; it.exp = e; it.frac = f; it.inf = inf; it.infrac = inff;
    return it;
  endfunction

  task automatic add_vec(input item_t it, input logic [31:0] se);
    vec_t v;
    v.it = it; v.s_exp = se;
    vq.push_back(v);
  endtask

  // Reference: value arithmetic on the raw sum, returns {flags, s}.
  function automatic logic [34:0] ref_model(input item_t it);
    longint v, mant, rem;
    int e, p, lzc, sh;
    bit up, away, inx;
    if (it.inf) return {3'b000, it.sign, 8'hFF, it.infrac};
    if (it.frac == 28'd0) return {3'b000, it.rm == 2'b01, 31'd0};
    v = longint'(it.frac);
    e = int'(it.exp);
    if (v >= (longint'(1) << 27)) begin
      v = (v >> 1) | (v & 1);
      e = e + 1;
    end else begin
      p = 26;
      while (((v >> p) & 1) == 0) p--;
      lzc = 26 - p;
      if (e > lzc) begin
        v = v << lzc;
        e = e - lzc;
      end else begin
        sh = (e > 0) ? e - 1 : 0;
        v = v << sh;
        e = 0;
      end
    end
    mant = v >> 3;
    rem  = v & 7;
    inx  = (rem != 0);
    case (it.rm)
      2'b00:   up = (rem > 4) || (rem == 4 && (mant % 2) == 1);
      2'b01:   up = it.sign && inx;
      2'b10:   up = !it.sign && inx;
      default: up = 1'b0;
    endcase
    if (up) mant = mant + 1;
    if (mant == (longint'(1) << 24)) begin
      mant = mant >> 1;
      e = e + 1;
    end
    if (e == 0 && mant >= (longint'(1) << 23)) e = 1;
    if (e >= 255) begin
      away = (it.rm == 2'b01 && it.sign) || (it.rm == 2'b10 && !it.sign);
      if (it.rm == 2'b00 || away) return {3'b101, it.sign, 8'hFF, 23'd0};
      return {3'b101, it.sign, 8'hFE, 23'h7FFFFF};
    end
    return {1'b0, e == 0 && inx, inx, it.sign, e[7:0], mant[22:0]};
  endfunction

  function automatic item_t rand_item();
    item_t it;
    int nb;
    it.rm   = 2'($urandom);
    it.sign = 1'($urandom);
    it.exp  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 30)) : 8'($urandom_range(1, 255));
    nb      = $urandom_range(1, 28);
    it.frac = 28'($urandom & ((32'd1 << nb) - 32'd1));
    if ($urandom_range(0, 19) == 0) it.frac = 28'd0;
    it.inf    = ($urandom_range(0, 15) == 0);
    it.infrac = 23'($urandom);
    return it;
  endfunction

  task automatic set_item(input item_t it);
    n_rm = it.rm; n_sign = it.sign; n_exp = it.exp; n_frac = it.frac;
    n_inf_nan = it.inf; n_inf_nan_frac = it.infrac;
  endtask

  // One cycle from a negedge: drive, settle, score handshakes, advance to next negedge.
  task automatic drive_cycle(input logic v, input item_t it, input logic ordy, output logic acc);
    logic [34:0] e;
    set_item(it);
    in_valid = v;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) expq.push_back(ref_model(it));
    if (out_valid && out_ready) begin
      consumed++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%h required=none", s);
      end else begin
        e = expq.pop_front();
        check("stream_s", s, e[31:0]);
`ifdef FADD_NORM_FLAGS_EN
        check("stream_flags", 32'(flags), 32'(e[34:32]));
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    set_item(v.it);
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check($sformatf("vec%0d_lat1_valid", idx), 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("vec%0d_lat2_valid", idx), 32'(out_valid), 32'd1);
    check($sformatf("vec%0d_s", idx), s, v.s_exp);
  endtask

  initial begin
    item_t bp[4];
    item_t it;
    logic  a;
    int    acc, c0, stale;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    set_item(mk(2'b00, 1'b0, 8'd0, 28'd0, 1'b0, 23'd0));

    // Reset state
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", s, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Directed vectors
    add_vec(mk(2'b00, 1'b0, 8'd127, 28'h8000000, 1'b0, 23'd0), 32'h40000000);
    add_vec(mk(2'b00, 1'b0, 8'd127, 28'h4000004, 1'b0, 23'd0), 32'h3F800000);
    add_vec(mk(2'b00, 1'b0, 8'd127, 28'h400000C, 1'b0, 23'd0), 32'h3F800002);
    add_vec(mk(2'b00, 1'b1, 8'd127, 28'h0000000, 1'b0, 23'd0), 32'h00000000);
    add_vec(mk(2'b01, 1'b0, 8'd127, 28'h0000000, 1'b0, 23'd0), 32'h80000000);
    add_vec(mk(2'b00, 1'b0, 8'd254, 28'h8000000, 1'b0, 23'd0), 32'h7F800000);
    add_vec(mk(2'b11, 1'b0, 8'd254, 28'h8000000, 1'b0, 23'd0), 32'h7F7FFFFF);
    add_vec(mk(2'b10, 1'b0, 8'd254, 28'h8000000, 1'b0, 23'd0), 32'h7F800000);
    add_vec(mk(2'b01, 1'b0, 8'd254, 28'h8000000, 1'b0, 23'd0), 32'h7F7FFFFF);
    add_vec(mk(2'b10, 1'b1, 8'd254, 28'h8000000, 1'b0, 23'd0), 32'hFF7FFFFF);
    add_vec(mk(2'b00, 1'b0, 8'd127, 28'h0000123, 1'b1, 23'h400000), 32'h7FC00000);
    add_vec(mk(2'b00, 1'b0, 8'd127, 28'h0400000, 1'b0, 23'd0), 32'h3D800000);
    add_vec(mk(2'b01, 1'b1, 8'd127, 28'h4000001, 1'b0, 23'd0), 32'hBF800001);
    add_vec(mk(2'b11, 1'b1, 8'd127, 28'h4000001, 1'b0, 23'd0), 32'hBF800000);
    add_vec(mk(2'b00, 1'b0, 8'd1,   28'h0000008, 1'b0, 23'd0), 32'h00000001);
    add_vec(mk(2'b00, 1'b0, 8'd1,   28'h3FFFFFC, 1'b0, 23'd0), 32'h00800000);
    add_vec(mk(2'b00, 1'b0, 8'd127, 28'hC000003, 1'b0, 23'd0), 32'h40400000);
    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) apply_vec(vq[i], i);
    @(posedge clk); @(negedge clk);

    // Backpressure: only two items fit while the output is stalled
    for (int i = 0; i < 4; i++)
      bp[i] = mk(2'($urandom), 1'($urandom), 8'($urandom_range(100, 150)),
                 28'($urandom) | 28'h4000000, 1'b0, 23'd0);
    acc = 0;
    c0 = consumed;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, bp[acc], 1'b0, a);
      if (a) acc++;
    end
    #1;
    check("bp_accepted", 32'(acc), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_s", s, expq[0][31:0]);
    for (int i = 0; i < 20; i++) begin
      if (acc < 4) begin
        drive_cycle(1'b1, bp[acc], 1'b1, a);
        if (a) acc++;
      end else begin
        drive_cycle(1'b0, bp[0], 1'b1, a);
      end
    end
    check("bp_all_accepted", 32'(acc), 32'd4);
    check("bp_all_out", 32'(consumed - c0), 32'd4);

    // Reset with two items in flight
    drive_cycle(1'b1, mk(2'b00, 1'b0, 8'd127, 28'h4000000, 1'b0, 23'd0), 1'b0, a);
    drive_cycle(1'b1, mk(2'b00, 1'b0, 8'd128, 28'h4000000, 1'b0, 23'd0), 1'b0, a);
    #1;
    check("inflight_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    in_valid = 1'b1;
    set_item(mk(2'b00, 1'b0, 8'd130, 28'h4000000, 1'b0, 23'd0));
    #1;
    check("rst_cycle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_s", s, 32'h0);
    expq.delete();
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk); #1;
      if (out_valid) stale++;
    end
    check("flush_no_stale", 32'(stale), 32'd0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      it = rand_item();
      drive_cycle($urandom_range(0, 3) != 0, it, $urandom_range(0, 9) < 7, a);
    end
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, it, 1'b1, a);
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
